// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl
// Block sequencer between the message packer and the SHA-256 compression
// core. It gathers 16 packed words into a local block buffer. It then starts
// the core with the correct init/chain flag and streams W[0..15] on 16
// consecutive cycles. It waits for the core's round-complete pulse and chains
// further blocks of the same message. After the final block it emits a
// one-cycle digest-ready pulse.
//
// Optional feature macro: SHA_CTRL_TIMEOUT_EN (RUN-state watchdog, sticky err).
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_word/in_valid    packed message word from the packer (valid/ready)
//   in_last             with the 16th word of a block: 1 = final block
//   in_ready            controller accepts a word (IDLE/COLLECT only)
//   core_start          one-cycle pulse on the first load beat
//   core_init           with core_start: 1 = load IV, 0 = chain
//   core_wdata/wvalid   block word stream to the core, 16 beats
//   core_done           one-cycle pulse from the core: rounds complete
//   digest_valid        one-cycle pulse: final digest available in the core
//   busy                high whenever the controller is not IDLE
//   block_count         blocks completed in the current message (saturating)
//   err                 sticky watchdog error (constant 0 without the macro)
module sha256_block_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_word,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  core_start,
  output logic                  core_init,
  output logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_wvalid,
  input  logic                  core_done,
  output logic                  digest_valid,
  output logic                  busy,
  output logic [15:0]           block_count,
  output logic                  err
);

  typedef enum logic [2:0] {IDLE, COLLECT, LOAD, RUN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] blk_buf [16];
  logic [3:0]            wcnt;
  logic [4:0]            lcnt;
  logic                  first_r;
  logic                  last_r;
  logic                  accept;
  logic [3:0]            wr_idx;

  // Handshake and status decode straight from the state register, so there
  // is no combinational path from any input to any output.
  assign in_ready = (state == IDLE) || (state == COLLECT);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign wr_idx   = (state == IDLE) ? 4'd0 : wcnt;

`ifdef SHA_CTRL_TIMEOUT_EN
  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;
  logic          err_r;

  assign err = err_r;
`else
  // No watchdog: err is constant 0. The comparison only keeps the parameter
  // referenced; it always evaluates to 0.
  assign err = (TIMEOUT_CYCLES < 0);
`endif

  // Block buffer. It has no reset because its contents are only read after
  // all 16 words of a block have been rewritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      blk_buf[wr_idx] <= in_word;
    end
  end

  // Main sequencer. All core-facing outputs are registered here.
  // The first load beat (start, init and W[0]) is launched on the same edge
  // that accepts the 16th word. lcnt then points at the next word to emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wcnt         <= 4'd0;
      lcnt         <= 5'd0;
      first_r      <= 1'b1;
      last_r       <= 1'b0;
      core_start   <= 1'b0;
      core_init    <= 1'b0;
      core_wdata   <= '0;
      core_wvalid  <= 1'b0;
      digest_valid <= 1'b0;
      block_count  <= 16'd0;
`ifdef SHA_CTRL_TIMEOUT_EN
      tcnt         <= '0;
      err_r        <= 1'b0;
`endif
    end else begin
      core_start   <= 1'b0;
      core_init    <= 1'b0;
      digest_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wcnt        <= 4'd1;
            block_count <= 16'd0;
            first_r     <= 1'b1;
            state       <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (wcnt == 4'd15) begin
              last_r      <= in_last;
              wcnt        <= 4'd0;
              lcnt        <= 5'd1;
              core_start  <= 1'b1;
              core_init   <= first_r;
              core_wdata  <= blk_buf[0];
              core_wvalid <= 1'b1;
              state       <= LOAD;
            end else begin
              wcnt <= wcnt + 4'd1;
            end
          end
        end
        LOAD: begin
          if (lcnt == 5'd16) begin
            core_wvalid <= 1'b0;
            core_wdata  <= '0;
            lcnt        <= 5'd0;
            state       <= RUN;
`ifdef SHA_CTRL_TIMEOUT_EN
            tcnt        <= '0;
`endif
          end else begin
            core_wdata <= blk_buf[lcnt[3:0]];
            lcnt       <= lcnt + 5'd1;
          end
        end
        RUN: begin
          // A core_done arriving in the same cycle as watchdog expiry wins.
          if (core_done) begin
            if (block_count != 16'hFFFF) begin
              block_count <= block_count + 16'd1;
            end
            first_r <= 1'b0;
            if (last_r) begin
              digest_valid <= 1'b1;
              state        <= DONE;
            end else begin
              state <= COLLECT;
            end
          end
`ifdef SHA_CTRL_TIMEOUT_EN
          else if (tcnt == TLIM) begin
            err_r   <= 1'b1;
            first_r <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        DONE: begin
          first_r <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha256_block_ctrl.md
# sha256_block_ctrl

Block sequencer between the message packer and the SHA-256 compression core. It collects 16 packed 32-bit words into a local block buffer and starts the core with the correct init/chain flag. It then streams the block to the core, waits for round completion, and chains successive blocks of one message. After the final block completes, it emits a one-cycle digest-ready pulse.

## Interface
- DATA_WIDTH, 32, word width (fixed at 32 for SHA-256)
- TIMEOUT_CYCLES, 128, watchdog limit in RUN (used only with SHA_CTRL_TIMEOUT_EN)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- in_word  in  DATA_WIDTH  packed message word from packer
- in_valid  in  1  in_word valid; transfer when in_valid & in_ready
- in_last  in  1  qualifies the 16th word of a block: 1 = final block of message
- in_ready  out  1  controller accepts a word this cycle
- core_start  out  1  one-cycle pulse, first cycle of block load
- core_init  out  1  valid with core_start: 1 = load IV, 0 = chain from previous hash
- core_wdata  out  DATA_WIDTH  block word W[i] to core
- core_wvalid  out  1  core_wdata valid, 16 consecutive cycles per block
- core_done  in  1  one-cycle pulse from core: 64 rounds complete
- digest_valid  out  1  one-cycle pulse: final digest available in core
- busy  out  1  high in any state other than IDLE
- block_count  out  16  blocks completed in current message
- err  out  1  sticky watchdog error (0 without SHA_CTRL_TIMEOUT_EN)

## Operation
- States: IDLE, COLLECT, LOAD, RUN, DONE.
- IDLE: in_ready=1.
  - An accepted word goes to buf[0], wcnt=1, block_count=0, first_r=1, state → COLLECT.
- COLLECT: in_ready=1.
  - Each accepted word goes to buf[wcnt], and wcnt increments.
  - On acceptance with wcnt==15: last_r<=in_last, wcnt<=0, state → LOAD.
  - in_last on words 1–15 is ignored.
- LOAD: in_ready=0.
  - lcnt runs 0..15, and core_wdata=buf[lcnt] with core_wvalid=1 each cycle.
  - core_start=1 and core_init=first_r only when lcnt==0.
  - After lcnt==15, state → RUN.
- RUN: in_ready=0.
  - On core_done: block_count<=block_count+1 (saturates at 0xFFFF), first_r<=0.
  - Then state → DONE if last_r, else COLLECT.
- DONE: digest_valid=1 for one cycle, first_r<=1, state → IDLE.
  - block_count holds until the next message's first word.
- core_done outside RUN is ignored.
- in_valid while in_ready=0 is not consumed.
- Reset at any point:
  - State goes to IDLE and wcnt, lcnt, first_r=1, last_r=0 are reset.
  - All outputs go to 0 except in_ready=1.
  - buf contents are not cleared (don't care).

## Timing
- Reset values: in_ready=1, core_start=0, core_init=0, core_wdata=0, core_wvalid=0, digest_valid=0, busy=0, block_count=0, err=0.
- core_start, core_init, core_wdata, core_wvalid and digest_valid are registered. in_ready and busy decode from the state register only, so there is no combinational input-to-output path.
- 16th word accepted at edge N:
  - core_start and W[0] are visible in cycle N+1.
  - W[15] is visible in cycle N+16.
  - RUN begins in cycle N+17.
- core_done sampled at edge M in RUN:
  - digest_valid is high in cycle M+1 (final block), or in_ready is high in cycle M+1 (chained block).
- Peak input throughput is 1 word/cycle in IDLE/COLLECT.

## Configuration
- SHA_CTRL_TIMEOUT_EN defined:
  - A counter clears on RUN entry and increments each RUN cycle without core_done.
  - When it reaches TIMEOUT_CYCLES: err<=1 (sticky until rst), state → IDLE, first_r<=1, and no digest_valid is issued.
  - core_done in the same cycle as expiry wins; no error is raised.
- Not defined: there is no counter, RUN waits indefinitely, err is tied to 0, and TIMEOUT_CYCLES is unused.

## Test plan
- Single block "abc":
  - Stimulus: words 0x61626380, 0x00000000 ×14, 0x00000018 with in_last=1, then core_done 64 cycles after RUN entry.
  - Response: one core_start with core_init=1; 16 core_wvalid beats in order; digest_valid one cycle after core_done; block_count=1.
- Two-block message (in_last=0 then 1):
  - First core_start has core_init=1, second has core_init=0.
  - Exactly one digest_valid, after the second core_done; block_count=2.
- Gapped input:
  - Stimulus: in_valid toggling 1/0 during COLLECT, and in_valid held high through LOAD/RUN.
  - Response: words are taken only when in_ready=1; 16 beats with no duplication or loss.
- Spurious inputs:
  - Stimulus: core_done pulsed in IDLE/COLLECT, and in_last=1 on word 5.
  - Response: no state change, no count change, and the block is treated per word-16 in_last.
- Reset mid-LOAD:
  - Stimulus: rst asserted after W[6] is emitted.
  - Response: core_wvalid=0 and busy=0 the next cycle; the next message starts with core_init=1.
- Watchdog (macro defined, TIMEOUT_CYCLES=128):
  - Stimulus: no core_done.
  - Response: err=1 and state IDLE after the 128th RUN cycle, digest_valid never asserted.
  - Without the macro: RUN persists for more than 1000 cycles and err stays 0.
